mac_datapath: RTL
=================

MAC_DATAPATH -- requirements
Module: mac_datapath

Interface
REQ-001 SHALL have parameter DATA_W, default 8, signed two's-complement operand width.
REQ-002 SHALL have parameter ACC_W, default 20, signed accumulator width (ACC_W >= 2*DATA_W).
REQ-003 SHALL have parameter CNT_W, default 6, accumulation-count width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port x_in  input  DATA_W  operand X data.
REQ-007 SHALL have port y_in  input  DATA_W  operand Y data.
REQ-008 SHALL have port x_ld  input  1  load x_in into X register (from controller).
REQ-009 SHALL have port y_ld  input  1  load y_in into Y register (from controller).
REQ-010 SHALL have port mult_sel  input  1  multiplier operand B select: 0 = Y register, 1 = X register (square).
REQ-011 SHALL have port sum_ld  input  1  accumulate product into sum.
REQ-012 SHALL have port sum_clr  input  1  synchronous clear of sum, count, overflow.
REQ-013 SHALL have port sum_out  output  ACC_W  registered accumulator value.
REQ-014 SHALL have port sum_valid  output  1  one-cycle pulse, cycle after an accumulate.
REQ-015 SHALL have port acc_cnt  output  CNT_W  accumulations since last clear.
REQ-016 SHALL have port ovf  output  1  sticky signed-overflow flag.

Function
REQ-017 SHALL load X register from x_in on an edge with x_ld=1, else hold; same for Y with y_ld; both may load in the same cycle.
REQ-018 SHALL form product = X_reg * (mult_sel ? X_reg : Y_reg), signed, full 2*DATA_W bits, sign-extended to ACC_W+1 before addition.
REQ-019 SHALL use register values present before the edge: operands loaded in cycle N are multiplied by a sum_ld in cycle N+1 or later (zero-latency combinational multiply, one-cycle accumulate).
REQ-020 SHALL, on sum_ld=1 and sum_clr=0, set sum_out <= sum_out + product, acc_cnt <= acc_cnt + 1 saturating at 2^CNT_W-1, sum_valid <= 1.
REQ-021 SHALL, on sum_clr=1, set sum_out, acc_cnt, ovf and sum_valid to 0 regardless of sum_ld (clear wins).
REQ-022 SHALL drive sum_valid to 0 in every cycle not following an accepted accumulate.
REQ-023 SHALL set ovf when the ACC_W+1-bit sum is outside the signed ACC_W range; ovf holds until sum_clr or reset.
REQ-024 SHALL leave X/Y loading independent of sum_clr/sum_ld; load and accumulate in the same cycle use the old operand values.

Reset
REQ-025 SHALL on reset=1 asynchronously set X, Y, sum_out, acc_cnt to 0 and ovf, sum_valid to 0.
REQ-026 SHALL discard any accumulate in flight when reset asserts mid-operation; first update after release occurs on the first rising edge with reset=0.

Configuration
REQ-027 SHALL with macro MAC_SAT_EN defined, clamp sum_out on overflow to 2^(ACC_W-1)-1 (positive) or -2^(ACC_W-1) (negative).
REQ-028 SHALL without MAC_SAT_EN, wrap sum_out modulo 2^ACC_W; ovf behaviour identical in both builds.

Structure
REQ-029 SHALL place DATA_W/ACC_W/CNT_W defaults and mult_sel encodings (MSEL_XY=0, MSEL_XX=1) in shared package mac_pkg.
REQ-030 SHALL implement add/overflow/saturation in one sub-module mac_acc; operand registers and mux stay in mac_datapath.

Verification
REQ-031 SHALL verify reset: assert reset mid-run with sum_out=500 -> all outputs 0 immediately, before next clk edge.
REQ-032 SHALL verify x_in=3,y_in=5 loaded, mult_sel=0, sum_ld for 4 cycles -> sum_out 15,30,45,60; acc_cnt=4; sum_valid pulses each following cycle.
REQ-033 SHALL verify x_in=-7, mult_sel=1, one sum_ld from 0 -> sum_out=49; x_in=-4,y_in=6, mult_sel=0, one sum_ld -> 25.
REQ-034 SHALL verify sum_clr and sum_ld together with sum_out=60 -> sum_out=0, acc_cnt=0, sum_valid=0 next cycle.
REQ-035 SHALL verify x=y=-128, 33 accumulates -> ovf=1; sum_out=524287 with MAC_SAT_EN, -507904 without; acc_cnt=33.
REQ-036 SHALL verify 70 accumulates of 1*1 -> acc_cnt holds 63, sum_out=70.

Source files
------------

// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg -- shared definitions for the MAC datapath slice.
//
// Purpose : default widths for mac_datapath / mac_acc and the encodings of
//           the multiplier operand-B select.
// Contents:
//   DATA_W_DEF  signed operand width default
//   ACC_W_DEF   signed accumulator width default (>= 2*DATA_W_DEF)
//   CNT_W_DEF   accumulation-count width default
//   MSEL_XY     mult_sel value selecting X * Y
//   MSEL_XX     mult_sel value selecting X * X (square)
// -----------------------------------------------------------------------------
package mac_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 20;
    localparam int CNT_W_DEF  = 6;

    localparam logic MSEL_XY = 1'b0;
    localparam logic MSEL_XX = 1'b1;

endpackage : mac_pkg

// File: rtl/mac_acc.sv
// -----------------------------------------------------------------------------
// mac_acc -- signed accumulator with overflow detection and optional clamp.
//
// Build option: define MAC_SAT_EN to clamp the sum to the signed ACC_W range
//               on overflow; otherwise the sum wraps modulo 2^ACC_W. The sticky
//               overflow flag behaves the same in both builds.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   product_i    signed PROD_W-bit product to accumulate
//   sum_ld_i     accumulate product_i into the sum
//   sum_clr_i    synchronous clear of sum, count, overflow, valid (wins)
//   sum_o        registered signed accumulator value
//   sum_valid_o  one-cycle pulse after an accepted accumulate
//   acc_cnt_o    accumulations since last clear, saturating
//   ovf_o        sticky signed-overflow flag
// -----------------------------------------------------------------------------
module mac_acc
    import mac_pkg::*;
#(
    parameter int PROD_W = 2 * DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [PROD_W-1:0] product_i,
    input  logic              sum_ld_i,
    input  logic              sum_clr_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              sum_valid_o,
    output logic [CNT_W-1:0]  acc_cnt_o,
    output logic              ovf_o
);

    logic signed [ACC_W-1:0] sum_q, sum_d;
    logic        [CNT_W-1:0] cnt_q, cnt_d;
    logic                    vld_q, vld_d;
    logic                    ovf_q, ovf_d;

    logic signed [ACC_W:0]   prod_ext;
    logic signed [ACC_W:0]   sum_ext;
    logic signed [ACC_W:0]   add_res;
    logic                    add_ovf;
    logic signed [ACC_W-1:0] add_out;

    // One guard bit above the accumulator so the true sum is always exact.
    assign prod_ext = $signed({{(ACC_W + 1 - PROD_W){product_i[PROD_W-1]}}, product_i});
    assign sum_ext  = $signed({sum_q[ACC_W-1], sum_q});
    assign add_res  = sum_ext + prod_ext;
    // Guard bit disagreeing with the ACC_W sign bit means the sum left the range.
    assign add_ovf  = add_res[ACC_W] ^ add_res[ACC_W-1];

`ifdef MAC_SAT_EN
    function automatic logic signed [ACC_W-1:0] sat_fn(input logic signed [ACC_W:0] v);
        if (v[ACC_W] == v[ACC_W-1]) begin
            return v[ACC_W-1:0];
        end else if (v[ACC_W]) begin
            return {1'b1, {(ACC_W - 1){1'b0}}};
        end else begin
            return {1'b0, {(ACC_W - 1){1'b1}}};
        end
    endfunction

    assign add_out = sat_fn(add_res);
`else
    assign add_out = add_res[ACC_W-1:0];
`endif

    always_comb begin
        sum_d = sum_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        vld_d = 1'b0;
        if (sum_clr_i) begin
            sum_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (sum_ld_i) begin
            sum_d = add_out;
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
            ovf_d = ovf_q | add_ovf;
            vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sum_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            vld_q <= vld_d;
        end
    end

    assign sum_o       = sum_q;
    assign acc_cnt_o   = cnt_q;
    assign ovf_o       = ovf_q;
    assign sum_valid_o = vld_q;

endmodule : mac_acc

// File: rtl/mac_datapath.sv
// -----------------------------------------------------------------------------
// mac_datapath -- operand registers, square/product mux, signed multiply,
//                 feeding the mac_acc accumulator.
//
// Build option: MAC_SAT_EN (see mac_acc) selects clamp instead of wrap.
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-high reset
//   x_in/y_in  signed DATA_W operand data
//   x_ld/y_ld  load x_in / y_in into the X / Y register
//   mult_sel   operand B select: MSEL_XY -> Y register, MSEL_XX -> X register
//   sum_ld     accumulate X * B into the sum
//   sum_clr    synchronous clear of sum, count, overflow (wins over sum_ld)
//   sum_out    registered signed accumulator
//   sum_valid  one-cycle pulse after an accepted accumulate
//   acc_cnt    accumulations since last clear, saturating
//   ovf        sticky signed-overflow flag
// -----------------------------------------------------------------------------
module mac_datapath
    import mac_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] x_in,
    input  logic [DATA_W-1:0] y_in,
    input  logic              x_ld,
    input  logic              y_ld,
    input  logic              mult_sel,
    input  logic              sum_ld,
    input  logic              sum_clr,
    output logic [ACC_W-1:0]  sum_out,
    output logic              sum_valid,
    output logic [CNT_W-1:0]  acc_cnt,
    output logic              ovf
);

    localparam int PROD_W = 2 * DATA_W;

    logic signed [DATA_W-1:0] x_q, x_d;
    logic signed [DATA_W-1:0] y_q, y_d;
    logic signed [DATA_W-1:0] b_op;
    logic        [PROD_W-1:0] x_ext;
    logic        [PROD_W-1:0] b_ext;
    logic        [PROD_W-1:0] product;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (x_ld) x_d = x_in;
        if (y_ld) y_d = y_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    // Operand stage: registered X/Y feed a combinational multiply, so an
    // accumulate in the same cycle as a load still sees the old operands.
    assign b_op = (mult_sel == MSEL_XX) ? x_q : y_q;

    // Low PROD_W bits of the product of sign-extended operands equal the
    // signed two's-complement product.
    assign x_ext   = {{DATA_W{x_q[DATA_W-1]}}, x_q};
    assign b_ext   = {{DATA_W{b_op[DATA_W-1]}}, b_op};
    assign product = x_ext * b_ext;

    mac_acc #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W),
        .CNT_W  (CNT_W)
    ) u_acc (
        .clk_i       (clk),
        .rst_i       (reset),
        .product_i   (product),
        .sum_ld_i    (sum_ld),
        .sum_clr_i   (sum_clr),
        .sum_o       (sum_out),
        .sum_valid_o (sum_valid),
        .acc_cnt_o   (acc_cnt),
        .ovf_o       (ovf)
    );

endmodule : mac_datapath
